// File: rtl/pt_threshold_unit.sv
// pt_threshold_unit
//   Adaptive threshold and RR-statistics stage of the Pan-Tompkins QRS
//   detector. It keeps signal and noise peak estimates for the integrated (i)
//   and filtered (f) channels, and two 8-deep RR-interval averages: one over
//   all intervals and one over regular intervals only. From these it derives
//   the detection thresholds and the missed-beat limit.
//
//   Stage A holds the estimates and the RR buffers. Stage B is recomputed from
//   Stage A on every enabled cycle, so outputs lag an input pulse by two edges.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   en                  clock enable; when low all state holds and pulses are lost
//   init_thrs           loads the initial estimates from the learning statistics
//   peak_*_max/_mean    learning-phase statistics (signed)
//   spu, npu, rru, load signal / noise / RR update, search-back marker
//   peak_i, peak_f      current peaks (signed)
//   peak_i_sb, peak_f_sb search-back peaks (signed)
//   rr_interval         current RR interval in samples (unsigned)
//   thri_1/2, thrf_1/2  primary and secondary thresholds (signed)
//   rrmiss              missed-beat limit (unsigned, saturating)
//   rr_avg1, rr_avg2    RR averages: all intervals / regular intervals
//   irregular           high when rr_avg1 != rr_avg2
module pt_threshold_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int RR_INIT    = 200
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         init_thrs,
    input  logic signed [DATA_WIDTH-1:0] peak_i_max,
    input  logic signed [DATA_WIDTH-1:0] peak_i_mean,
    input  logic signed [DATA_WIDTH-1:0] peak_f_max,
    input  logic signed [DATA_WIDTH-1:0] peak_f_mean,
    input  logic                         spu,
    input  logic                         npu,
    input  logic                         rru,
    input  logic                         load,
    input  logic signed [DATA_WIDTH-1:0] peak_i,
    input  logic signed [DATA_WIDTH-1:0] peak_f,
    input  logic signed [DATA_WIDTH-1:0] peak_i_sb,
    input  logic signed [DATA_WIDTH-1:0] peak_f_sb,
    input  logic        [DATA_WIDTH-1:0] rr_interval,
    output logic signed [DATA_WIDTH-1:0] thri_1,
    output logic signed [DATA_WIDTH-1:0] thri_2,
    output logic signed [DATA_WIDTH-1:0] thrf_1,
    output logic signed [DATA_WIDTH-1:0] thrf_2,
    output logic        [DATA_WIDTH-1:0] rrmiss,
    output logic        [DATA_WIDTH-1:0] rr_avg1,
    output logic        [DATA_WIDTH-1:0] rr_avg2,
    output logic                         irregular
);

    localparam int W  = DATA_WIDTH;
    localparam int IW = DATA_WIDTH + 2;
    localparam int SW = DATA_WIDTH + 3;
    localparam int RRMISS_RAW  = RR_INIT + RR_INIT / 2 + RR_INIT / 8 + RR_INIT / 32;
    localparam int RRMISS_MAX  = (1 << DATA_WIDTH) - 1;
    localparam int RRMISS_INIT = (RRMISS_RAW > RRMISS_MAX) ? RRMISS_MAX : RRMISS_RAW;

    // Stage A state
    logic signed [W-1:0] spki, npki, spkf, npkf;
    logic signed [W-1:0] spki_n, npki_n, spkf_n, npkf_n;
    logic        [W-1:0] buf1 [8];
    logic        [W-1:0] buf2 [8];
    logic        [2:0]   ptr1, ptr2;
    logic        [SW-1:0] sum1, sum2;

    function automatic logic signed [IW-1:0] ext(input logic signed [W-1:0] v);
        return {{2{v[W-1]}}, v};
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] hi;
        logic signed [IW-1:0] lo;
        hi = {3'b000, {(W-1){1'b1}}};
        lo = {3'b111, {(W-1){1'b0}}};
        if (v > hi)      return W'(hi);
        else if (v < lo) return W'(lo);
        else             return W'(v);
    endfunction

    // est += (target - est) >>> sh, saturated to the signed data range
    function automatic logic signed [W-1:0] track(input logic signed [W-1:0] est,
                                                  input logic signed [W-1:0] target,
                                                  input int unsigned sh);
        logic signed [IW-1:0] d;
        d = ext(target) - ext(est);
        return sat(ext(est) + (d >>> sh));
    endfunction

    function automatic logic signed [W-1:0] thr_primary(input logic signed [W-1:0] spk,
                                                        input logic signed [W-1:0] npk);
        logic signed [IW-1:0] t;
        t = ext(npk) + ((ext(spk) - ext(npk)) >>> 2);
        return W'(t);
    endfunction

    always_comb begin
        spki_n = spki;
        npki_n = npki;
        spkf_n = spkf;
        npkf_n = npkf;
        if (init_thrs) begin
            spki_n = peak_i_max >>> 1;
            npki_n = peak_i_mean >>> 1;
            spkf_n = peak_f_max >>> 1;
            npkf_n = peak_f_mean >>> 1;
        end else if (spu && load) begin
            spki_n = track(spki, peak_i_sb, 2);
            spkf_n = track(spkf, peak_f_sb, 2);
        end else if (spu) begin
            spki_n = track(spki, peak_i, 3);
            spkf_n = track(spkf, peak_f, 3);
        end else if (npu) begin
            npki_n = track(npki, peak_i, 3);
            npkf_n = track(npkf, peak_f, 3);
        end
    end

    // Regular-interval window around the current rr_avg2 output
    logic          rr_valid;
    logic [W-1:0]  rr_low;
    logic [W:0]    rr_high;
    logic          rr_regular;

    always_comb begin
        rr_valid   = rru && (rr_interval != '0);
        rr_low     = rr_avg2 - (rr_avg2 >> 4) - (rr_avg2 >> 6);
        rr_high    = {1'b0, rr_avg2} + {1'b0, rr_avg2 >> 3} + {1'b0, rr_avg2 >> 5};
        rr_regular = (rr_interval >= rr_low) && ({1'b0, rr_interval} <= rr_high);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spki <= '0;
            npki <= '0;
            spkf <= '0;
            npkf <= '0;
            for (int unsigned k = 0; k < 8; k++) begin
                buf1[k] <= W'(RR_INIT);
                buf2[k] <= W'(RR_INIT);
            end
            ptr1 <= '0;
            ptr2 <= '0;
            sum1 <= SW'(8 * RR_INIT);
            sum2 <= SW'(8 * RR_INIT);
        end else if (en) begin
            spki <= spki_n;
            npki <= npki_n;
            spkf <= spkf_n;
            npkf <= npkf_n;
            if (rr_valid) begin
                buf1[ptr1] <= rr_interval;
                sum1       <= sum1 + SW'(rr_interval) - SW'(buf1[ptr1]);
                ptr1       <= ptr1 + 3'd1;
                if (rr_regular) begin
                    buf2[ptr2] <= rr_interval;
                    sum2       <= sum2 + SW'(rr_interval) - SW'(buf2[ptr2]);
                    ptr2       <= ptr2 + 3'd1;
                end
            end
        end
    end

    // Stage B
    logic        [W-1:0]  avg1_c, avg2_c;
    logic                 irr_c;
    logic        [W+1:0]  miss_c;
    logic        [W-1:0]  miss_sat;
    logic signed [W-1:0]  ti1_c, ti2_c, tf1_c, tf2_c;

    always_comb begin
        avg1_c   = W'(sum1 >> 3);
        avg2_c   = W'(sum2 >> 3);
        irr_c    = (avg1_c != avg2_c);
        miss_c   = {2'b00, avg2_c} + {3'b000, avg2_c >> 1}
                 + {2'b00, avg2_c >> 3} + {2'b00, avg2_c >> 5};
        miss_sat = (miss_c[W+1:W] != 2'b00) ? '1 : W'(miss_c);
        ti1_c    = thr_primary(spki, npki);
        tf1_c    = thr_primary(spkf, npkf);
        ti2_c    = ti1_c >>> 1;
        tf2_c    = tf1_c >>> 1;
        // secondary is derived from the un-halved primary, then both halve
        if (irr_c) begin
            ti1_c = ti1_c >>> 1;
            ti2_c = ti2_c >>> 1;
            tf1_c = tf1_c >>> 1;
            tf2_c = tf2_c >>> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thri_1    <= '0;
            thri_2    <= '0;
            thrf_1    <= '0;
            thrf_2    <= '0;
            rr_avg1   <= W'(RR_INIT);
            rr_avg2   <= W'(RR_INIT);
            rrmiss    <= W'(RRMISS_INIT);
            irregular <= 1'b0;
        end else if (en) begin
            thri_1    <= ti1_c;
            thri_2    <= ti2_c;
            thrf_1    <= tf1_c;
            thrf_2    <= tf2_c;
            rr_avg1   <= avg1_c;
            rr_avg2   <= avg2_c;
            rrmiss    <= miss_sat;
            irregular <= irr_c;
        end
    end

endmodule

// File: doc/pt_threshold_unit.md
# pt_threshold_unit

Adaptive threshold and RR-statistics stage of the Pan-Tompkins QRS detector. It sits directly downstream of `control_unit`. It consumes the classification pulses (`spu`, `npu`, `rru`, `load`, `init_thrs`) together with the peak and RR data. It produces the thresholds (`thri_1/2`, `thrf_1/2`) and `rrmiss`, which `control_unit` compares against. It keeps separate signal and noise peak estimates for the integrated (i) and filtered (f) channels, plus two 8-deep RR-interval averages.

## Interface
- DATA_WIDTH, 16, width of all peak, threshold and RR values
- RR_INIT, 200, reset value of every RR buffer entry, in samples (1 s at 200 Hz)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  clock enable; when 0, all state holds and input pulses are ignored
- init_thrs  in  1  one-cycle pulse; loads the initial peak estimates
- peak_i_max, peak_i_mean, peak_f_max, peak_f_mean  in  DATA_WIDTH signed  learning-phase statistics
- spu, npu, rru, load  in  1  signal-peak update, noise-peak update, RR update, search-back marker
- peak_i, peak_f  in  DATA_WIDTH signed  current peaks
- peak_i_sb, peak_f_sb  in  DATA_WIDTH signed  search-back peaks
- rr_interval  in  DATA_WIDTH unsigned  current RR interval, in samples
- thri_1, thri_2, thrf_1, thrf_2  out  DATA_WIDTH signed  primary and secondary thresholds
- rrmiss  out  DATA_WIDTH unsigned  missed-beat limit
- rr_avg1, rr_avg2  out  DATA_WIDTH unsigned  RR averages (all intervals / regular intervals only)
- irregular  out  1  high when rr_avg1 != rr_avg2

## Operation
- Stage A registers: SPKI, NPKI, SPKF, NPKF; two 8-entry RR ring buffers (buf1, buf2), each with a 3-bit write pointer and a running sum of DATA_WIDTH+3 bits.
- Peak-estimate updates, in priority order per enabled cycle:
  - init_thrs: SPKx = peak_x_max>>>1; NPKx = peak_x_mean>>>1. Overrides spu and npu in the same cycle.
  - spu && load (search-back): SPKx += (peak_x_sb − SPKx)>>>2.
  - spu: SPKx += (peak_x − SPKx)>>>3.
  - npu (only when spu=0): NPKx += (peak_x − NPKx)>>>3.
- Estimate arithmetic: signed, DATA_WIDTH+2 internal bits, arithmetic shifts. Results saturate to the signed DATA_WIDTH range.
- RR updates, on rru with rr_interval != 0 (rru with rr_interval == 0 is ignored):
  - buf1: write rr_interval at ptr1; sum1 += rr_interval − old entry; ptr1 wraps 7 → 0.
  - buf2: same write and sum update, but only if RRlow ≤ rr_interval ≤ RRhigh.
  - RRlow = A − (A>>4) − (A>>6); RRhigh = A + (A>>3) + (A>>5), where A is the current rr_avg2 output.
- rru is independent of spu and npu; any combination may occur in the same cycle.
- Stage B registers, recomputed on every enabled cycle from the Stage A values:
  - THRx1 = NPKx + ((SPKx − NPKx)>>>2); THRx2 = THRx1>>>1.
  - rr_avg1 = sum1>>3; rr_avg2 = sum2>>3.
  - rrmiss = A + (A>>1) + (A>>3) + (A>>5), with A = sum2>>3; saturates at the unsigned maximum.
  - irregular = (sum1>>3) != (sum2>>3).
  - When irregular, the thr outputs present THRx1>>>1 and THRx2>>>1.

## Timing
- Input pulse sampled at edge T: Stage A updates at T, outputs reflect it after edge T+1 (2-cycle latency).
- Buffer-2 range check uses the rr_avg2 output as it stands at edge T.
- Reset values:
  - SPK/NPK = 0.
  - All buffer entries = RR_INIT; sums = 8·RR_INIT; pointers = 0.
  - thr outputs = 0.
  - rr_avg1 = rr_avg2 = RR_INIT.
  - rrmiss = RR_INIT-derived value (331 for 200).
  - irregular = 0.
- Reset mid-operation: immediate return to the reset values; no partial update completes.
- en=0 for any number of cycles: outputs hold, pulses are lost; behaviour resumes on the first cycle with en=1.
- spu and npu together: only the SPK update applies.

## Test plan
- Reset, then idle: thri_1=thri_2=thrf_1=thrf_2=0, rr_avg1=rr_avg2=200, rrmiss=331, irregular=0.
- init_thrs with peak_i_max=800, peak_i_mean=400: SPKI=400, NPKI=200; two cycles later thri_1=250, thri_2=125.
- After that init, spu with peak_i=1200 → thri_1=275, thri_2=137. Separately, npu with peak_i=600 from the init state → thri_1=287, thri_2=143.
- Search-back from the init state (spu=load=1, peak_i_sb=800, peak_i=0): SPKI=500; plain spu in the same state with peak_i=800 gives SPKI=450.
- rru with rr_interval=240 from reset: rr_avg1=205 and rr_avg2=200 (240 > 231); irregular=1 and thri outputs halved. Then rru with 210: rr_avg2=201.
- 8 consecutive rru of 240: rr_avg1=240, pointer back at 0; en=0 during a spu pulse leaves all outputs unchanged; spu and npu together alter only SPKI.
